mont_exp: RTL

Left-to-right square-and-multiply modular exponentiation sequencer that sits directly upstream of the `montgomery` multiplier.
- Latches a base already in the Montgomery domain, an exponent, the modulus and R mod M.
- Issues one `montgomery` operation at a time and feeds each result back as the next operand.
- Finishes with a multiply by 1 to leave the Montgomery domain and presents the plain result x^e mod M to the RSA top level.

---
 rtl/mont_exp.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mont_exp.sv
// -----------------------------------------------------------------------------
// mont_exp
// Left-to-right square-and-multiply modular exponentiation sequencer. It sits
// directly in front of a `montgomery` multiplier, issues one Montgomery
// operation at a time, feeds every result back as the next operand and ends
// with a multiply by 1 so that `result` is the plain value x^e mod M.
//
// Optional feature macro: MONT_EXP_CT_EN
//   defined   : constant-time mode, a multiply is issued for every exponent bit
//               and its product is only kept when the bit is 1
//               (2*exp_len+1 operations).
//   undefined : multiplies are skipped for zero bits
//               (exp_len + popcount(e) + 1 operations).
//
// Parameters
//   WIDTH : operand width, must match the multiplier.
//   EXPW  : width of exp_len, 2^EXPW > WIDTH.
//
// Ports
//   clk, resetn          : clock (rising edge), asynchronous active-low reset
//   start                : one-cycle request, ignored while busy
//   in_xt, in_r          : base in Montgomery form, R mod M
//   in_e, in_m           : exponent, odd modulus
//   exp_len              : number of exponent bits to process (0..WIDTH)
//   mul_start            : one-cycle start pulse to the multiplier
//   mul_a, mul_b, mul_m  : multiplier operands (registered)
//   mul_result, mul_done : multiplier result (top two bits unused), level done
//   result               : x^e mod M, valid with done and held until next done
//   busy                 : high from the cycle after an accepted start up to
//                          and including the done cycle
//   done                 : one-cycle completion pulse
// -----------------------------------------------------------------------------
module mont_exp #(
  parameter int WIDTH = 512,
  parameter int EXPW  = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_xt,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_e,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [EXPW-1:0]    exp_len,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic [WIDTH-1:0]   mul_m,
  input  logic [WIDTH+1:0]   mul_result,
  input  logic               mul_done,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  // ARM states give the multiplier one cycle to drop the done level left over
  // from its previous operation; mul_done is never looked at there.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SQR_ISSUE  = 4'd1,
    ST_SQR_ARM    = 4'd2,
    ST_SQR_WAIT   = 4'd3,
    ST_MUL_ISSUE  = 4'd4,
    ST_MUL_ARM    = 4'd5,
    ST_MUL_WAIT   = 4'd6,
    ST_NEXT       = 4'd7,
    ST_POST_ISSUE = 4'd8,
    ST_POST_ARM   = 4'd9,
    ST_POST_WAIT  = 4'd10
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [EXPW-1:0]  ONE_E  = {{(EXPW-1){1'b0}}, 1'b1};
  localparam logic [EXPW-1:0]  ZERO_E = {EXPW{1'b0}};

  state_t             state_r;
  state_t             state_s;

  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_s;
  logic [WIDTH-1:0]   xt_r;
  logic [WIDTH-1:0]   xt_s;
  logic [WIDTH-1:0]   e_r;
  logic [WIDTH-1:0]   e_s;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   m_s;
  logic [EXPW-1:0]    idx_r;
  logic [EXPW-1:0]    idx_s;

  logic               mul_start_r;
  logic               mul_start_s;
  logic [WIDTH-1:0]   mul_a_r;
  logic [WIDTH-1:0]   mul_a_s;
  logic [WIDTH-1:0]   mul_b_r;
  logic [WIDTH-1:0]   mul_b_s;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_s;
  logic               busy_r;
  logic               busy_s;
  logic               done_r;
  logic               done_s;

  logic               accept_s;
  logic [WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]   e_shift_s;
  logic               e_bit_s;
  logic [1:0]         mul_result_unused_s;

  // busy_r is still high in the done cycle, so a start there is not accepted.
  assign accept_s  = (state_r == ST_IDLE) && start && !busy_r;
  assign prod_s    = mul_result[WIDTH-1:0];
  // Shift instead of a variable bit-select: idx_r is wider than a WIDTH index.
  assign e_shift_s = e_r >> idx_r;
  assign e_bit_s   = e_shift_s[0];
  // The multiplier's two extra headroom bits carry nothing we need.
  assign mul_result_unused_s = mul_result[WIDTH+1:WIDTH];

  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign mul_m     = m_r;
  assign result    = result_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the square / multiply / post-multiply sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (exp_len == ZERO_E) begin
            state_s = ST_POST_ISSUE;
          end else begin
            state_s = ST_SQR_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SQR_ISSUE: state_s = ST_SQR_ARM;
      ST_SQR_ARM:   state_s = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (mul_done) begin
`ifdef MONT_EXP_CT_EN
          state_s = ST_MUL_ISSUE;
`else
          if (e_bit_s) begin
            state_s = ST_MUL_ISSUE;
          end else begin
            state_s = ST_NEXT;
          end
`endif
        end else begin
          state_s = ST_SQR_WAIT;
        end
      end
      ST_MUL_ISSUE: state_s = ST_MUL_ARM;
      ST_MUL_ARM:   state_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_done) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_MUL_WAIT;
        end
      end
      ST_NEXT: begin
        if (idx_r == ZERO_E) begin
          state_s = ST_POST_ISSUE;
        end else begin
          state_s = ST_SQR_ISSUE;
        end
      end
      ST_POST_ISSUE: state_s = ST_POST_ARM;
      ST_POST_ARM:   state_s = ST_POST_WAIT;
      ST_POST_WAIT: begin
        if (mul_done) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_POST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    acc_s       = acc_r;
    xt_s        = xt_r;
    e_s         = e_r;
    m_s         = m_r;
    idx_s       = idx_r;
    result_s    = result_r;
    done_s      = 1'b0;
    mul_start_s = 1'b0;
    mul_a_s     = mul_a_r;
    mul_b_s     = mul_b_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          xt_s  = in_xt;
          e_s   = in_e;
          m_s   = in_m;
          acc_s = in_r;
          idx_s = exp_len - ONE_E;
        end else begin
          acc_s = acc_r;
        end
      end
      ST_SQR_WAIT: begin
        if (mul_done) begin
          acc_s = prod_s;
        end else begin
          acc_s = acc_r;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
`ifdef MONT_EXP_CT_EN
          // Dummy multiply for a zero bit: product is dropped.
          acc_s = e_bit_s ? prod_s : acc_r;
`else
          acc_s = prod_s;
`endif
        end else begin
          acc_s = acc_r;
        end
      end
      ST_NEXT: begin
        if (idx_r != ZERO_E) begin
          idx_s = idx_r - ONE_E;
        end else begin
          idx_s = idx_r;
        end
      end
      ST_POST_WAIT: begin
        if (mul_done) begin
          result_s = prod_s;
          done_s   = 1'b1;
        end else begin
          result_s = result_r;
        end
      end
      default: begin
        acc_s = acc_r;
      end
    endcase

    // Operands are loaded on entry to an ISSUE state and then held, so they
    // stay stable until the matching WAIT state exits. acc_s already holds a
    // product that is being written back on this same edge.
    case (state_s)
      ST_SQR_ISSUE: begin
        mul_start_s = 1'b1;
        mul_a_s     = acc_s;
        mul_b_s     = acc_s;
      end
      ST_MUL_ISSUE: begin
        mul_start_s = 1'b1;
        mul_a_s     = acc_s;
        mul_b_s     = xt_s;
      end
      ST_POST_ISSUE: begin
        mul_start_s = 1'b1;
        mul_a_s     = acc_s;
        mul_b_s     = ONE_W;
      end
      default: begin
        mul_start_s = 1'b0;
        mul_a_s     = mul_a_r;
        mul_b_s     = mul_b_r;
      end
    endcase

    busy_s = (state_s != ST_IDLE) || done_s;
  end

  // Datapath and registered output update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r       <= ZERO_W;
      xt_r        <= ZERO_W;
      e_r         <= ZERO_W;
      m_r         <= ZERO_W;
      idx_r       <= ZERO_E;
      mul_start_r <= 1'b0;
      mul_a_r     <= ZERO_W;
      mul_b_r     <= ZERO_W;
      result_r    <= ZERO_W;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      acc_r       <= acc_s;
      xt_r        <= xt_s;
      e_r         <= e_s;
      m_r         <= m_s;
      idx_r       <= idx_s;
      mul_start_r <= mul_start_s;
      mul_a_r     <= mul_a_s;
      mul_b_r     <= mul_b_s;
      result_r    <= result_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

endmodule
